// File: rtl/calc_pipe.sv
// Three-stage signed calculator Q = (A - B) * (1 + 3*C) - 4*D with valid/ready flow control.
// Optional macro CALC_PIPE_SAT_EN clamps narrow outputs instead of wrapping them.
module calc_pipe #(
    parameter int A_DWIDTH = 32,
    parameter int B_DWIDTH = 32,
    parameter int C_DWIDTH = 32,
    parameter int D_DWIDTH = 32,
    parameter int Q_DWIDTH = ((((A_DWIDTH > B_DWIDTH) ? A_DWIDTH : B_DWIDTH) + C_DWIDTH) > D_DWIDTH
                              ? (((A_DWIDTH > B_DWIDTH) ? A_DWIDTH : B_DWIDTH) + C_DWIDTH)
                              : D_DWIDTH) + 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic signed [A_DWIDTH-1:0] a_i,
    input  logic signed [B_DWIDTH-1:0] b_i,
    input  logic signed [C_DWIDTH-1:0] c_i,
    input  logic signed [D_DWIDTH-1:0] d_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic signed [Q_DWIDTH-1:0] q_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       sat_o
);

    localparam int AB_W   = (A_DWIDTH > B_DWIDTH) ? A_DWIDTH : B_DWIDTH;
    localparam int DIFF_W = AB_W + 1;
    localparam int K_W    = C_DWIDTH + 2;
    localparam int D4_W   = D_DWIDTH + 2;
    localparam int PROD_W = DIFF_W + K_W;
    localparam int FULL_W = ((AB_W + C_DWIDTH) > D_DWIDTH ? (AB_W + C_DWIDTH) : D_DWIDTH) + 4;

    logic adv;
    logic vld_p0, vld_p1, vld_p2;

    logic signed [DIFF_W-1:0]   diff_c, diff_p0;
    logic signed [K_W-1:0]      k_c, k_p0;
    logic signed [D4_W-1:0]     d4_c, d4_p0, d4_p1;
    logic signed [PROD_W-1:0]   prod_c, prod_p1;
    logic signed [FULL_W-1:0]   full_c;
    logic signed [Q_DWIDTH-1:0] q_c, q_p2;
    logic                       sat_c, sat_p2;

    // One enable for the whole pipe: it moves unless a finished result is waiting on the sink.
    assign adv     = ~vld_p2 | ready_i;
    assign ready_o = adv;

    // S1: operand pre-processing, all widened before arithmetic
    assign diff_c = DIFF_W'(a_i) - DIFF_W'(b_i);
    assign k_c    = K_W'(c_i) + (K_W'(c_i) <<< 1) + K_W'(1);
    assign d4_c   = D4_W'(d_i) <<< 2;

    // S2: full-precision product
    assign prod_c = PROD_W'(diff_p0) * PROD_W'(k_p0);

    // S3: final subtract at lossless width, then width reduction
    assign full_c = FULL_W'(prod_p1) - FULL_W'(d4_p1);

    generate
        if (Q_DWIDTH < FULL_W) begin : g_narrow
`ifdef CALC_PIPE_SAT_EN
            localparam logic signed [Q_DWIDTH-1:0] Q_MAX = {1'b0, {(Q_DWIDTH-1){1'b1}}};
            localparam logic signed [Q_DWIDTH-1:0] Q_MIN = ~Q_MAX;

            function automatic logic out_of_range(input logic signed [FULL_W-1:0] v);
                return (v > FULL_W'(Q_MAX)) || (v < FULL_W'(Q_MIN));
            endfunction

            function automatic logic signed [Q_DWIDTH-1:0] sat_q(input logic signed [FULL_W-1:0] v);
                if (v > FULL_W'(Q_MAX))
                    return Q_MAX;
                else if (v < FULL_W'(Q_MIN))
                    return Q_MIN;
                else
                    return v[Q_DWIDTH-1:0];
            endfunction

            assign q_c   = sat_q(full_c);
            assign sat_c = out_of_range(full_c);
`else
            function automatic logic signed [Q_DWIDTH-1:0] wrap_q(input logic signed [FULL_W-1:0] v);
                return v[Q_DWIDTH-1:0];
            endfunction

            assign q_c   = wrap_q(full_c);
            assign sat_c = 1'b0;
`endif
        end else begin : g_wide
            assign q_c   = Q_DWIDTH'(full_c);
            assign sat_c = 1'b0;
        end
    endgenerate

    // Control and output registers: reset so nothing stale is ever presented.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p0 <= 1'b0;
            vld_p1 <= 1'b0;
            vld_p2 <= 1'b0;
            q_p2   <= '0;
            sat_p2 <= 1'b0;
        end else if (adv) begin
            vld_p0 <= valid_i;
            vld_p1 <= vld_p0;
            vld_p2 <= vld_p1;
            q_p2   <= q_c;
            sat_p2 <= sat_c;
        end
    end

    always_ff @(posedge clk_i) begin
        if (adv) begin
            diff_p0 <= diff_c;
            k_p0    <= k_c;
            d4_p0   <= d4_c;
            prod_p1 <= prod_c;
            d4_p1   <= d4_p0;
        end
    end

    assign valid_o = vld_p2;
    assign q_o     = q_p2;
    assign sat_o   = sat_p2;

endmodule

// File: tb/tb_calc_pipe.sv
// Randomised bench for calc_pipe: scoreboard against the arithmetic formula, plus
// directed latency, extreme-value, stall, narrow-output and mid-flight reset cases.
module tb_calc_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i;
    logic signed [31:0] a_i, b_i, c_i, d_i;
    logic               valid_i, ready_o, valid_o, ready_i, sat_o;
    logic signed [67:0] q_o;

    logic signed [31:0] a16, b16, c16, d16;
    logic               v16_i, r16_o, v16_o, rdy16_i, sat16;
    logic signed [15:0] q16;

    calc_pipe dut (
        .clk_i(clk), .rst_i(rst_i),
        .a_i(a_i), .b_i(b_i), .c_i(c_i), .d_i(d_i),
        .valid_i(valid_i), .ready_o(ready_o),
        .q_o(q_o), .valid_o(valid_o), .ready_i(ready_i), .sat_o(sat_o)
    );

    calc_pipe #(.Q_DWIDTH(16)) dut16 (
        .clk_i(clk), .rst_i(rst_i),
        .a_i(a16), .b_i(b16), .c_i(c16), .d_i(d16),
        .valid_i(v16_i), .ready_o(r16_o),
        .q_o(q16), .valid_o(v16_o), .ready_i(rdy16_i), .sat_o(sat16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0, in_cyc = 0, out_cyc = 0, n_out = 0;
    logic acc;
    logic prev_stall = 1'b0;
    logic signed [67:0]  prev_q = '0;
    logic signed [127:0] exp_q[$];
    logic signed [127:0] obs[$];

    task automatic check(input string tag, input logic signed [127:0] got, input logic signed [127:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    function automatic logic signed [127:0] model(input logic signed [31:0] a, input logic signed [31:0] b,
                                                  input logic signed [31:0] c, input logic signed [31:0] d);
        logic signed [127:0] ta, tb, tc, td;
        ta = a; tb = b; tc = c; td = d;
        return (ta - tb) * (1 + 3 * tc) - 4 * td;
    endfunction

    function automatic logic signed [127:0] model16(input logic signed [127:0] full, output logic sat);
        logic signed [15:0] w;
        sat = 1'b0;
`ifdef CALC_PIPE_SAT_EN
        if (full > 32767) begin
            sat = 1'b1;
            return 32767;
        end
        if (full < -32768) begin
            sat = 1'b1;
            return -32768;
        end
        return full;
`else
        w = full[15:0];
        return w;
`endif
    endfunction

    // One clock: inputs already set after a falling edge; sample 1ns later, then advance.
    task automatic tick();
        #1;
        acc = valid_i && ready_o;
        if (exp_q.size() == 3 && !ready_i) check("full_ready", ready_o, 0);
        if (exp_q.size() < 3 && ready_i) check("free_ready", ready_o, 1);
        if (prev_stall) begin
            check("stall_valid", valid_o, 1);
            check("stall_q", q_o, prev_q);
        end
        prev_stall = valid_o && !ready_i;
        prev_q = q_o;
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) check("spurious_out", valid_o, 0);
            else begin
                check("q", q_o, exp_q.pop_front());
                check("sat", sat_o, 0);
            end
            obs.push_back(q_o);
            out_cyc = cyc;
            n_out++;
        end
        if (acc) begin
            exp_q.push_back(model(a_i, b_i, c_i, d_i));
            in_cyc = cyc;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic signed [31:0] a, input logic signed [31:0] b,
                        input logic signed [31:0] c, input logic signed [31:0] d);
        int k = 0;
        a_i = a; b_i = b; c_i = c; d_i = d;
        valid_i = 1'b1;
        acc = 1'b0;
        while (!acc && k < 20) begin
            tick();
            k++;
        end
        valid_i = 1'b0;
        if (!acc) check("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int k = 0;
        ready_i = 1'b1;
        valid_i = 1'b0;
        while (exp_q.size() > 0 && k < 30) begin
            tick();
            k++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic rand_ops();
        logic signed [31:0] v[4];
        for (int i = 0; i < 4; i++) begin
            case ($urandom_range(0, 3))
                0: v[i] = $signed(32'($urandom_range(0, 200))) - 100;
                1: case ($urandom_range(0, 3))
                       0: v[i] = 32'sh7fffffff;
                       1: v[i] = 32'sh80000000;
                       2: v[i] = 0;
                       default: v[i] = -1;
                   endcase
                default: v[i] = $signed($urandom);
            endcase
        end
        a_i = v[0]; b_i = v[1]; c_i = v[2]; d_i = v[3];
    endtask

    task automatic run16(input logic signed [31:0] a, input logic signed [31:0] c, input string tag);
        logic signed [127:0] want;
        logic want_sat;
        logic seen = 1'b0;
        want = model16(model(a, 0, c, 0), want_sat);
        a16 = a; b16 = 0; c16 = c; d16 = 0;
        v16_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v16_i = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            #1;
            if (v16_o) begin
                seen = 1'b1;
                check({tag, "_q"}, q16, want);
                check({tag, "_sat"}, sat16, want_sat);
            end
            @(posedge clk);
            @(negedge clk);
        end
        if (!seen) check({tag, "_timeout"}, 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, sent, out0;
        logic pending;
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1;
        a_i = 0; b_i = 0; c_i = 0; d_i = 0;
        a16 = 0; b16 = 0; c16 = 0; d16 = 0; v16_i = 1'b0; rdy16_i = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_q", q_o, 0);
        check("rst_sat", sat_o, 0);
        check("rst_ready", ready_o, 1);
        check("rst16_valid", v16_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        // Single beat and its latency
        send(10, 3, 2, 1);
        drain();
        check("t1_q", obs[$], 45);
        check("t1_latency", out_cyc - in_cyc, 3);

        // Small known beats
        send(0, 5, -1, 0);
        send(1, 2, 0, 3);
        drain();
        check("t2_q0", obs[obs.size()-2], 10);
        check("t2_q1", obs[$], -13);

        // Extreme operands at full output width
        send(32'sh7fffffff, 32'sh80000000, 32'sh7fffffff, 32'sh80000000);
        drain();

        // Eight beats with the sink stalled for cycles 4..9
        t = 0; sent = 0; pending = 1'b0; out0 = n_out;
        while ((sent < 8 || exp_q.size() > 0) && t < 200) begin
            ready_i = !(t >= 4 && t <= 9);
            if (sent < 8 && !pending) begin
                rand_ops();
                pending = 1'b1;
            end
            valid_i = pending;
            tick();
            if (acc) begin
                sent++;
                pending = 1'b0;
            end
            t++;
        end
        valid_i = 1'b0;
        check("t4_count", n_out - out0, 8);
        check("t4_left", exp_q.size(), 0);

        // Random traffic on both sides
        pending = 1'b0; sent = 0; out0 = n_out;
        for (int i = 0; i < 400; i++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            if (!pending && $urandom_range(0, 4) != 0) begin
                rand_ops();
                pending = 1'b1;
            end
            valid_i = pending;
            tick();
            if (acc) begin
                sent++;
                pending = 1'b0;
            end
        end
        valid_i = 1'b0;
        drain();
        check("rand_count", n_out - out0, sent);

        // Narrow output: out-of-range and in-range results
        run16(10000, 10000, "t5_big");
        run16(100, 1, "t5_small");
        run16(-10000, 10000, "t5_neg");

        // Reset with three beats in flight
        ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            valid_i = 1'b1;
            tick();
        end
        valid_i = 1'b0;
        #2 rst_i = 1'b1;
        #1;
        check("t6_valid", valid_o, 0);
        check("t6_q", q_o, 0);
        exp_q.delete();
        prev_stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        send(-7, 4, 3, -2);
        drain();
        check("t6_after", obs[$], model(-7, 4, 3, -2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
